// File: rtl/popcount_accumulator.sv
// Windowed accumulator of one-hot population-count codes, Tiny Tapeout pin interface.
// Optional LIVE_SUM_EN: uo_out tracks the running sum while accumulating.
module popcount_accumulator #(
  parameter int WINDOW = 16,
  parameter int SUM_W  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // state | meaning
  // IDLE  | waiting for start, last result held on uo_out
  // ACCUM | summing valid samples of the current window
  // DONE  | window closed, result and done held until ack/start
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  localparam logic [SUM_W:0] SUM_MAX = {1'b0, {SUM_W{1'b1}}};
  localparam logic [7:0]     LAST    = 8'(WINDOW - 1);

  state_t           state, state_nx;
  logic [SUM_W:0]   acc, acc_nx;
  logic [7:0]       cnt, cnt_nx;
  logic [SUM_W-1:0] result, result_nx;
  logic             err, err_nx;
  logic             sat, sat_nx;

  logic [4:0]       code;
  logic             valid, start, ack;
  logic             legal;
  logic [2:0]       weight;
  logic [SUM_W:0]   sum_raw, sum_sat;
  logic             clip;

  wire unused_pins = &{1'b0, uio_in};

  assign code  = ui_in[4:0];
  assign valid = ui_in[5];
  assign start = ui_in[6];
  assign ack   = ui_in[7];
  assign legal = $onehot(code);

  always_comb begin
    weight = 3'd0;
    case (code)
      5'b00001: weight = 3'd0;
      5'b00010: weight = 3'd1;
      5'b00100: weight = 3'd2;
      5'b01000: weight = 3'd3;
      5'b10000: weight = 3'd4;
      default:  weight = 3'd0;
    endcase
  end

  // Accumulator never exceeds SUM_MAX, so one extra bit is enough to detect the clip.
  assign sum_raw = acc + (SUM_W+1)'(weight);
  assign clip    = (sum_raw > SUM_MAX);
  assign sum_sat = clip ? SUM_MAX : sum_raw;

  always_comb begin
    state_nx  = state;
    acc_nx    = acc;
    cnt_nx    = cnt;
    result_nx = result;
    err_nx    = err;
    sat_nx    = sat;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = ACCUM;
          acc_nx   = '0;
          cnt_nx   = '0;
          err_nx   = 1'b0;
          sat_nx   = 1'b0;
        end
      end
      ACCUM: begin
        if (start) begin
          acc_nx = '0;
          cnt_nx = '0;
          err_nx = 1'b0;
          sat_nx = 1'b0;
        end else if (valid) begin
          acc_nx = sum_sat;
          cnt_nx = cnt + 8'd1;
          if (clip)   sat_nx = 1'b1;
          if (!legal) err_nx = 1'b1;
          if (cnt == LAST) begin
            state_nx  = DONE;
            result_nx = sum_sat[SUM_W-1:0];
          end
        end
      end
      DONE: begin
        if (start) begin
          state_nx = ACCUM;
          acc_nx   = '0;
          cnt_nx   = '0;
          err_nx   = 1'b0;
          sat_nx   = 1'b0;
        end else if (ack) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      result <= '0;
      err    <= 1'b0;
      sat    <= 1'b0;
    end else if (ena) begin
      state  <= state_nx;
      acc    <= acc_nx;
      cnt    <= cnt_nx;
      result <= result_nx;
      err    <= err_nx;
      sat    <= sat_nx;
    end
  end

`ifdef LIVE_SUM_EN
  assign uo_out = 8'((state == ACCUM) ? acc[SUM_W-1:0] : result);
`else
  assign uo_out = 8'(result);
`endif

  assign uio_out = {4'b0000, sat, (state == ACCUM), err, (state == DONE)};
  assign uio_oe  = 8'h0F;

endmodule

// File: tb/tb_popcount_accumulator.sv
// Directed self-checking bench for popcount_accumulator (default and WINDOW=100 instances).
module tb_popcount_accumulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  logic [7:0] uo_out_w, uio_out_w, uio_oe_w;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  popcount_accumulator dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uo_out(uo_out), .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  popcount_accumulator #(.WINDOW(100), .SUM_W(8)) dut_w100 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
    .uo_out(uo_out_w), .uio_in(uio_in), .uio_out(uio_out_w), .uio_oe(uio_oe_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    ui_in = 8'h40;
    tick();
    ui_in = 8'h00;
  endtask

  task automatic run_samples(input logic [4:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      ui_in = {3'b001, c};
      tick();
    end
    ui_in = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (uo_out !== 8'd0) begin errors++; $display("FAIL reset_uo got %0d exp 0", uo_out); end
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_flags got %h exp 00", uio_out); end
    checks++; if (uio_oe !== 8'h0F) begin errors++; $display("FAIL reset_oe got %h exp 0f", uio_oe); end
    rst_n = 1'b1;
    run_samples(5'b00100, 3);
    checks++; if (uio_out !== 8'h00) begin errors++; $display("FAIL idle_ignores_valid got %h exp 00", uio_out); end
  endtask

  task automatic test_basic();
    pulse_start();
    checks++; if (uio_out !== 8'h04) begin errors++; $display("FAIL start_busy got %h exp 04", uio_out); end
    run_samples(5'b00100, 15);
    checks++; if (uio_out !== 8'h04) begin errors++; $display("FAIL basic_15 got %h exp 04", uio_out); end
    run_samples(5'b00100, 1);
    checks++; if (uio_out !== 8'h01) begin errors++; $display("FAIL basic_done got %h exp 01", uio_out); end
    checks++; if (uo_out !== 8'd32) begin errors++; $display("FAIL basic_sum got %0d exp 32", uo_out); end
    run_samples(5'b10000, 2);
    checks++; if (uo_out !== 8'd32 || uio_out !== 8'h01) begin errors++; $display("FAIL done_hold got %0d/%h exp 32/01", uo_out, uio_out); end
  endtask

  task automatic test_mixed();
    pulse_start();
    run_samples(5'b10000, 8);
    run_samples(5'b00001, 8);
    checks++; if (uo_out !== 8'd32 || uio_out !== 8'h01) begin errors++; $display("FAIL mixed got %0d/%h exp 32/01", uo_out, uio_out); end
    ui_in = 8'h80;
    tick();
    ui_in = 8'h00;
    checks++; if (uio_out !== 8'h00 || uo_out !== 8'd32) begin errors++; $display("FAIL ack got %0d/%h exp 32/00", uo_out, uio_out); end
  endtask

  task automatic test_illegal();
    pulse_start();
    run_samples(5'b00010, 7);
    run_samples(5'b00011, 1);
    checks++; if (uio_out !== 8'h06) begin errors++; $display("FAIL illegal_err got %h exp 06", uio_out); end
    run_samples(5'b00010, 7);
    checks++; if (uio_out !== 8'h06) begin errors++; $display("FAIL illegal_15 got %h exp 06", uio_out); end
    run_samples(5'b00010, 1);
    checks++; if (uo_out !== 8'd15 || uio_out !== 8'h03) begin errors++; $display("FAIL illegal_done got %0d/%h exp 15/03", uo_out, uio_out); end
  endtask

  task automatic test_saturation();
    pulse_start();
    checks++; if (uio_out_w !== 8'h04) begin errors++; $display("FAIL sat_clear got %h exp 04", uio_out_w); end
    run_samples(5'b10000, 63);
    checks++; if (uio_out_w !== 8'h04) begin errors++; $display("FAIL sat_63 got %h exp 04", uio_out_w); end
    run_samples(5'b10000, 1);
    checks++; if (uio_out_w !== 8'h0C) begin errors++; $display("FAIL sat_64 got %h exp 0c", uio_out_w); end
    run_samples(5'b10000, 36);
    checks++; if (uo_out_w !== 8'd255 || uio_out_w !== 8'h09) begin errors++; $display("FAIL sat_done got %0d/%h exp 255/09", uo_out_w, uio_out_w); end
    checks++; if (uo_out !== 8'd64 || uio_out !== 8'h01) begin errors++; $display("FAIL w16_in_sat got %0d/%h exp 64/01", uo_out, uio_out); end
  endtask

  task automatic test_ena();
    pulse_start();
    run_samples(5'b01000, 7);
    ena = 1'b0;
    ui_in = {3'b011, 5'b01000};
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (uio_out !== 8'h04 || uo_out !== 8'd64) begin errors++; $display("FAIL ena_gap%0d got %0d/%h exp 64/04", i, uo_out, uio_out); end
    end
    ui_in = 8'h00;
    ena = 1'b1;
    run_samples(5'b01000, 8);
    checks++; if (uio_out !== 8'h04) begin errors++; $display("FAIL ena_15 got %h exp 04", uio_out); end
    run_samples(5'b01000, 1);
    checks++; if (uo_out !== 8'd48 || uio_out !== 8'h01) begin errors++; $display("FAIL ena_done got %0d/%h exp 48/01", uo_out, uio_out); end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    run_samples(5'b00100, 10);
    rst_n = 1'b0;
    ui_in = {3'b001, 5'b00100};
    tick();
    ui_in = 8'h00;
    rst_n = 1'b1;
    checks++; if (uo_out !== 8'd0 || uio_out !== 8'h00) begin errors++; $display("FAIL reset_mid got %0d/%h exp 0/00", uo_out, uio_out); end
  endtask

  task automatic test_restart();
    pulse_start();
    run_samples(5'b00100, 9);
    run_samples(5'b00110, 1);
    checks++; if (uio_out !== 8'h06) begin errors++; $display("FAIL restart_pre_err got %h exp 06", uio_out); end
    ui_in = {3'b011, 5'b10000};
    tick();
    ui_in = 8'h00;
    checks++; if (uio_out !== 8'h04) begin errors++; $display("FAIL restart_clear got %h exp 04", uio_out); end
    run_samples(5'b00010, 15);
    checks++; if (uio_out !== 8'h04) begin errors++; $display("FAIL restart_15 got %h exp 04", uio_out); end
    run_samples(5'b00010, 1);
    checks++; if (uo_out !== 8'd16 || uio_out !== 8'h01) begin errors++; $display("FAIL restart_done got %0d/%h exp 16/01", uo_out, uio_out); end
  endtask

  task automatic test_start_ack();
    logic [7:0] exp_uo;
`ifdef LIVE_SUM_EN
    exp_uo = 8'd0;
`else
    exp_uo = 8'd16;
`endif
    ui_in = 8'hC0;
    tick();
    ui_in = 8'h00;
    checks++; if (uio_out !== 8'h04 || uo_out !== exp_uo) begin errors++; $display("FAIL start_ack got %0d/%h exp %0d/04", uo_out, uio_out, exp_uo); end
    run_samples(5'b00001, 16);
    checks++; if (uo_out !== 8'd0 || uio_out !== 8'h01) begin errors++; $display("FAIL zero_window got %0d/%h exp 0/01", uo_out, uio_out); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mixed();
    test_illegal();
    test_saturation();
    test_ena();
    test_reset_mid();
    test_restart();
    test_start_ack();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
